// File: rtl/vga_pkg.sv
// Shared VGA timing defaults (640x480@60 with a 4-clk pixel) and a
// constant-width helper used when sizing counters.
package vga_pkg;

  localparam int H_DISPLAY_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int V_DISPLAY_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;
  localparam int CLK_DIV_DEF   = 4;
  localparam int COORD_W_DEF   = 10;
  localparam int FRAME_W_DEF   = 16;

  // Bits needed to hold the values 0..value-1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < value) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/pixel_tick_div.sv
// Pixel-rate divider: counts 0..CLK_DIV-1 while en is high and flags the
// cycle in which a new pixel starts.
module pixel_tick_div
  import vga_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  output logic p_tick
);

  localparam int DIV_W = (CLK_DIV > 1) ? clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;

  // Divider next state; the count freezes while en is low.
  always_comb begin
    div_d = div_q;
    if (en) begin
      if (div_q == DIV_LAST) begin
        div_d = '0;
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end else begin
      div_d = div_q;
    end
  end

  // Divider register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  // Strobe consumed in the same edge by the parent, which registers it.
  assign p_tick = en && (div_q == '0);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel/line/frame counters with registered sync, blanking
// and strobe outputs that always match the x/y visible in the same cycle.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   H_DISPLAY = H_DISPLAY_DEF,
  parameter int   H_FRONT   = H_FRONT_DEF,
  parameter int   H_SYNC    = H_SYNC_DEF,
  parameter int   H_BACK    = H_BACK_DEF,
  parameter int   V_DISPLAY = V_DISPLAY_DEF,
  parameter int   V_FRONT   = V_FRONT_DEF,
  parameter int   V_SYNC    = V_SYNC_DEF,
  parameter int   V_BACK    = V_BACK_DEF,
  parameter int   CLK_DIV   = CLK_DIV_DEF,
  parameter logic HSYNC_POL = 1'b0,
  parameter logic VSYNC_POL = 1'b0,
  parameter int   COORD_W   = COORD_W_DEF,
  parameter int   FRAME_W   = FRAME_W_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               en,
  output logic               hsync,
  output logic               vsync,
  output logic               video_on,
  output logic               p_tick,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int CW1     = COORD_W + 1;

  localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W:0] H_DISP_C   = CW1'(H_DISPLAY);
  localparam logic [COORD_W:0] HS_START_C = CW1'(H_DISPLAY + H_FRONT);
  localparam logic [COORD_W:0] HS_END_C   = CW1'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [COORD_W:0] V_DISP_C   = CW1'(V_DISPLAY);
  localparam logic [COORD_W:0] VS_START_C = CW1'(V_DISPLAY + V_FRONT);
  localparam logic [COORD_W:0] VS_END_C   = CW1'(V_DISPLAY + V_FRONT + V_SYNC);

  if (COORD_W < 1 || COORD_W > 30 || FRAME_W < 1 ||
      H_DISPLAY < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
      V_DISPLAY < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1 ||
      H_TOTAL > (1 << COORD_W) || V_TOTAL > (1 << COORD_W) ||
      CLK_DIV < 1 || CLK_DIV > 256) begin : g_bad_params
    $error("vga_timing_gen: illegal timing parameters");
  end

  logic               tick_s;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic               primed_q, primed_d;
  logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
  logic               p_tick_q;
  logic               line_start_q, line_start_d;
  logic               frame_start_q, frame_start_d;
  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;
  logic               video_on_q, video_on_d;
  logic [COORD_W:0]   xe_s, ye_s;

  pixel_tick_div #(
    .CLK_DIV (CLK_DIV)
  ) u_div (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en),
    .p_tick  (tick_s)
  );

  // Raster counters; the first tick after reset presents 0,0 without advancing.
  always_comb begin
    x_d         = x_q;
    y_d         = y_q;
    primed_d    = primed_q;
    frame_cnt_d = frame_cnt_q;
    if (tick_s) begin
      if (!primed_q) begin
        primed_d = 1'b1;
      end else if (x_q == H_LAST) begin
        x_d = '0;
        if (y_q == V_LAST) begin
          y_d         = '0;
          frame_cnt_d = frame_cnt_q + FRAME_W'(1);
        end else begin
          y_d = y_q + COORD_W'(1);
        end
      end else begin
        x_d = x_q + COORD_W'(1);
      end
    end else begin
      primed_d = primed_q;
    end
  end

  // Decode from the next x/y so registered flags line up with registered x/y.
  always_comb begin
    xe_s          = {1'b0, x_d};
    ye_s          = {1'b0, y_d};
    hsync_d       = ((xe_s >= HS_START_C) && (xe_s < HS_END_C)) ? HSYNC_POL : ~HSYNC_POL;
    vsync_d       = ((ye_s >= VS_START_C) && (ye_s < VS_END_C)) ? VSYNC_POL : ~VSYNC_POL;
    video_on_d    = (xe_s < H_DISP_C) && (ye_s < V_DISP_C);
    line_start_d  = tick_s && (x_d == '0);
    frame_start_d = tick_s && (x_d == '0) && (y_d == '0);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      x_q           <= '0;
      y_q           <= '0;
      primed_q      <= 1'b0;
      frame_cnt_q   <= '0;
      p_tick_q      <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      hsync_q       <= ~HSYNC_POL;
      vsync_q       <= ~VSYNC_POL;
      video_on_q    <= 1'b0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      primed_q      <= primed_d;
      frame_cnt_q   <= frame_cnt_d;
      p_tick_q      <= tick_s;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign frame_cnt   = frame_cnt_q;
  assign p_tick      = p_tick_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default, inverted-polarity and tiny
// timing instances sharing one clock.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic        rst_def, en_def, hs_def, vs_def, vid_def, pt_def, ls_def, fs_def;
  logic [9:0]  x_def, y_def;
  logic [15:0] fc_def;

  logic        rst_pol, en_pol, hs_pol, vs_pol, vid_pol, pt_pol, ls_pol, fs_pol;
  logic [9:0]  x_pol, y_pol;
  logic [15:0] fc_pol;

  logic        rst_sml, en_sml, hs_sml, vs_sml, vid_sml, pt_sml, ls_sml, fs_sml;
  logic [9:0]  x_sml, y_sml;
  logic [1:0]  fc_sml;

  vga_timing_gen u_def (
    .clk(clk), .reset_n(rst_def), .en(en_def), .hsync(hs_def), .vsync(vs_def),
    .video_on(vid_def), .p_tick(pt_def), .x(x_def), .y(y_def),
    .line_start(ls_def), .frame_start(fs_def), .frame_cnt(fc_def)
  );

  vga_timing_gen #(
    .V_DISPLAY(3), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
  ) u_pol (
    .clk(clk), .reset_n(rst_pol), .en(en_pol), .hsync(hs_pol), .vsync(vs_pol),
    .video_on(vid_pol), .p_tick(pt_pol), .x(x_pol), .y(y_pol),
    .line_start(ls_pol), .frame_start(fs_pol), .frame_cnt(fc_pol)
  );

  vga_timing_gen #(
    .H_DISPLAY(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_DISPLAY(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .CLK_DIV(1), .FRAME_W(2)
  ) u_sml (
    .clk(clk), .reset_n(rst_sml), .en(en_sml), .hsync(hs_sml), .vsync(vs_sml),
    .video_on(vid_sml), .p_tick(pt_sml), .x(x_sml), .y(y_sml),
    .line_start(ls_sml), .frame_start(fs_sml), .frame_cnt(fc_sml)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Packs {x, y, hsync, vsync, video_on, p_tick, line_start, frame_start, frame_cnt[5:0]}.
  function automatic logic [31:0] pk(input logic [9:0] px, input logic [9:0] py,
                                     input logic hs, input logic vs, input logic vid,
                                     input logic pt, input logic ls, input logic fs,
                                     input logic [5:0] fc);
    return {px, py, hs, vs, vid, pt, ls, fs, fc};
  endfunction

  function automatic logic [31:0] def_obs();
    return pk(x_def, y_def, hs_def, vs_def, vid_def, pt_def, ls_def, fs_def, fc_def[5:0]);
  endfunction

  function automatic logic [31:0] sml_obs();
    return pk(x_sml, y_sml, hs_sml, vs_sml, vid_sml, pt_sml, ls_sml, fs_sml, {4'b0000, fc_sml});
  endfunction

  typedef struct {
    logic        rst_n;
    logic        en;
    logic [31:0] exp;
  } vec_t;

  vec_t        tbl [15];
  int          cnt, first_pt, hs_lo, hs_hi, vs_lo, vs_hi;
  logic [9:0]  hs_x, px, py;
  logic [31:0] snap;

  initial begin
    tbl[0]  = '{1'b0, 1'b1, pk(10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0)};
    tbl[1]  = '{1'b1, 1'b0, pk(10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0)};
    tbl[2]  = '{1'b1, 1'b0, pk(10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0)};
    tbl[3]  = '{1'b1, 1'b1, pk(10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 6'd0)};
    tbl[4]  = '{1'b1, 1'b1, pk(10'd1, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0)};
    tbl[5]  = '{1'b1, 1'b1, pk(10'd2, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0)};
    tbl[6]  = '{1'b1, 1'b0, pk(10'd2, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0)};
    tbl[7]  = '{1'b1, 1'b1, pk(10'd3, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0)};
    tbl[8]  = '{1'b1, 1'b1, pk(10'd4, 10'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0)};
    tbl[9]  = '{1'b1, 1'b1, pk(10'd5, 10'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0)};
    tbl[10] = '{1'b1, 1'b1, pk(10'd6, 10'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0)};
    tbl[11] = '{1'b1, 1'b1, pk(10'd7, 10'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0)};
    tbl[12] = '{1'b1, 1'b1, pk(10'd0, 10'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 6'd0)};
    tbl[13] = '{1'b0, 1'b1, pk(10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0)};
    tbl[14] = '{1'b1, 1'b1, pk(10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 6'd0)};

    rst_def = 1'b0; en_def = 1'b1;
    rst_pol = 1'b0; en_pol = 1'b1;
    rst_sml = 1'b0; en_sml = 1'b1;
    repeat (3) @(negedge clk);
    check("def_reset", def_obs(), pk(10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0));
    check("pol_reset_idle", 32'({hs_pol, vs_pol}), 32'd0);

    // Tiny timing: cycle-by-cycle table.
    for (int i = 0; i < 15; i++) begin
      rst_sml = tbl[i].rst_n;
      en_sml  = tbl[i].en;
      @(negedge clk);
      check($sformatf("sml_vec%0d", i), sml_obs(), tbl[i].exp);
    end

    // Tiny timing: four whole frames, frame_cnt wraps 3 -> 0 on the fourth.
    for (int f = 1; f <= 4; f++) begin
      cnt = 0; vs_lo = 0; px = 10'd0; py = 10'd0;
      do begin
        px = x_sml; py = y_sml;
        @(negedge clk);
        cnt++;
        if (!vs_sml) vs_lo++;
      end while (!fs_sml && cnt < 200);
      check($sformatf("sml_frame%0d_period", f), 32'(cnt), 32'd48);
      check($sformatf("sml_frame%0d_wrap_from", f), 32'({px, py}), 32'({10'd7, 10'd5}));
      check($sformatf("sml_frame%0d_wrap_to", f), 32'({x_sml, y_sml}), 32'd0);
      check($sformatf("sml_frame%0d_cnt", f), 32'(fc_sml), 32'(f % 4));
      check($sformatf("sml_frame%0d_vsync_lo", f), 32'(vs_lo), 32'd8);
    end

    // Defaults: release, then one full line.
    rst_def = 1'b1;
    @(negedge clk);
    check("def_release", def_obs(), pk(10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 6'd0));
    cnt = 0; first_pt = 0; hs_lo = 0; hs_x = 10'd0;
    do begin
      @(negedge clk);
      cnt++;
      if (pt_def && first_pt == 0) first_pt = cnt;
      if (!hs_def) begin
        if (hs_lo == 0) hs_x = x_def;
        hs_lo++;
      end
    end while (!ls_def && cnt < 4000);
    check("def_ptick_period", 32'(first_pt), 32'd4);
    check("def_hsync_lo", 32'(hs_lo), 32'd384);
    check("def_hsync_first_x", 32'(hs_x), 32'd656);
    check("def_line_period", 32'(cnt), 32'd3200);
    check("def_line1_y", 32'(y_def), 32'd1);

    // Defaults: en low for 10 clk mid-line stretches the line by 10 clk.
    cnt = 0; snap = 32'd0;
    do begin
      @(negedge clk);
      cnt++;
      if (cnt == 1001) begin
        snap   = def_obs();
        en_def = 1'b0;
      end else if (cnt > 1001 && cnt <= 1011) begin
        check("def_freeze", def_obs(), snap);
        if (cnt == 1011) en_def = 1'b1;
      end
    end while (!ls_def && cnt < 4000);
    check("def_stretched_period", 32'(cnt), 32'd3210);
    check("def_line2_y", 32'(y_def), 32'd2);

    // Defaults: one-clk reset at x=700.
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (x_def != 10'd700 && cnt < 4000);
    check("def_reach_700", 32'(x_def), 32'd700);
    rst_def = 1'b0;
    @(negedge clk);
    check("def_midreset", def_obs(), pk(10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0));
    rst_def = 1'b1;
    @(negedge clk);
    check("def_midreset_release", def_obs(), pk(10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 6'd0));

    // Inverted polarity: one full 7-line frame.
    rst_pol = 1'b1;
    @(negedge clk);
    check("pol_release", 32'({fs_pol, hs_pol, vs_pol}), 32'b100);
    cnt = 0; hs_hi = 0; vs_hi = 0;
    do begin
      @(negedge clk);
      cnt++;
      if (hs_pol) hs_hi++;
      if (vs_pol) vs_hi++;
    end while (!fs_pol && cnt < 30000);
    check("pol_frame_period", 32'(cnt), 32'd22400);
    check("pol_hsync_hi", 32'(hs_hi), 32'd2688);
    check("pol_vsync_hi", 32'(vs_hi), 32'd6400);
    check("pol_frame_cnt", 32'(fc_pol), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
